// File: rtl/spi_slave_param.sv
// SPI slave, parameterised frame width / CPOL / CPHA / bit order, sampled in the CLK domain.
// Latency: SCK/MOSI/CSbar see 2-flop sync + 1 edge-detect cycle; RX_VALID the cycle after the last sample edge.
// Backpressure: none on the SPI side; TX_READY gates TX_LOAD (loads while full are dropped).
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to float MISO (1'bz) outside ACTIVE, else it drives 0.
module spi_slave_param #(
  parameter int WIDTH     = 16,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCK,
  input  logic             MOSI,
  input  logic             CSbar,
  output logic             MISO,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY
);

  localparam int   CW       = $clog2(WIDTH + 1);
  localparam logic CPOL_LVL = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sck_sync;
  logic [1:0]       cs_sync;
  logic [1:0]       mosi_sync;
  logic             sck_rise, sck_fall, lead_edge, trail_edge;
  logic             sample_edge, shift_edge;
  logic             cs_high, mosi_s, start, last_bit, drive_en;
  logic [WIDTH-1:0] hold, tx_shift, rx_shift, rx_next, start_word;
  logic             hold_empty, miso_bit;
  logic [CW-1:0]    bit_cnt;

  // First bit to leave the shifter for the configured bit order
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Shifter contents once the head bit has been consumed
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Synchronisers; SCK keeps a third stage so edges are seen on the synchronised level
  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_sync  <= {3{CPOL_LVL}};
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      cs_sync   <= {cs_sync[0], CSbar};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign lead_edge   = CPOL_LVL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL_LVL ? sck_rise : sck_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_high     = cs_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign start       = (state == IDLE) && !cs_high;
  assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
  assign start_word  = hold_empty ? '0 : hold;
  assign rx_next     = (MSB_FIRST != 0) ? {rx_shift[WIDTH-2:0], mosi_s}
                                        : {mosi_s, rx_shift[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: chip select governs entry/exit, last sample closes the frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_high) state_nxt = ACTIVE;
      ACTIVE:  if (cs_high) state_nxt = IDLE;
               else if (sample_edge && last_bit) state_nxt = DONE;
      DONE:    if (cs_high) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy while selected, MISO only driven mid-frame
  always_comb begin
    BUSY     = (state != IDLE);
    drive_en = (state == ACTIVE);
  end

  // Datapath: holding register, TX/RX shifters, bit counter, RX word and strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold       <= '0;
      hold_empty <= 1'b1;
      tx_shift   <= '0;
      miso_bit   <= 1'b0;
      rx_shift   <= '0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      RX_VALID <= 1'b0;
      if (start) begin
        // CPHA=0 presents bit 0 immediately; CPHA=1 waits for the first shift edge
        if (CPHA != 0) begin
          tx_shift <= start_word;
          miso_bit <= 1'b0;
        end else begin
          tx_shift <= adv(start_word);
          miso_bit <= head(start_word);
        end
        rx_shift   <= '0;
        bit_cnt    <= '0;
        hold_empty <= 1'b1;
      end else if (state == ACTIVE && !cs_high) begin
        if (shift_edge) begin
          miso_bit <= head(tx_shift);
          tx_shift <= adv(tx_shift);
        end
        if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + CW'(1);
          if (last_bit) begin
            RX_DATA  <= rx_next;
            RX_VALID <= 1'b1;
          end
        end
      end
      // A load coinciding with frame start is kept for the following frame
      if (TX_LOAD && hold_empty) begin
        hold       <= TX_DATA;
        hold_empty <= 1'b0;
      end
    end
  end

  assign TX_READY = hold_empty;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = drive_en ? miso_bit : 1'bz;
`else
  assign MISO = drive_en ? miso_bit : 1'b0;
`endif

endmodule
